// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_INSTR_W = 32;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: a valid bit and a payload register.
// Clear wins over load on the valid bit; the payload only changes on load.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Valid bit tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (ld_i) begin
      valid_q <= 1'b1;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Payload register, loads only when the slot is filled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= {W{1'b0}};
    end else if (ld_i) begin
      data_q <= data_i;
    end else begin
      data_q <= data_q;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/if_id_stage_reg.sv
// IF->ID stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional macro IF_ID_BUBBLE_NOP_EN forces a NOP bubble onto out_* while out_valid is low.
module if_id_stage_reg
  import pipe_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int PW = ADDR_W + INSTR_W;

  stage_state_e  state_q, state_d;
  logic          main_ld_s, main_clr_s, main_sel_skid_s;
  logic          skid_ld_s, skid_clr_s;
  logic          main_valid_s, skid_valid_s;
  logic [PW-1:0] main_din_s, main_data_s, skid_data_s, in_data_s;
  logic          in_xfer_s, out_xfer_s;

  assign in_data_s  = {in_pc, in_instr};
  // in_ready is the inverted skid valid register, so it never depends on out_ready
  assign in_ready   = ~skid_valid_s;
  assign out_valid  = main_valid_s;
  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and slot control; flush overrides every transfer
  always_comb begin
    state_d         = state_q;
    main_ld_s       = 1'b0;
    main_clr_s      = 1'b0;
    main_sel_skid_s = 1'b0;
    skid_ld_s       = 1'b0;
    skid_clr_s      = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      main_clr_s = 1'b1;
      skid_clr_s = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer_s) begin
            main_ld_s = 1'b1;
            state_d   = FULL;
          end else begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (in_xfer_s && out_xfer_s) begin
            main_ld_s = 1'b1;
            state_d   = FULL;
          end else if (in_xfer_s) begin
            skid_ld_s = 1'b1;
            state_d   = SKID;
          end else if (out_xfer_s) begin
            main_clr_s = 1'b1;
            state_d    = EMPTY;
          end else begin
            state_d = FULL;
          end
        end
        SKID: begin
          if (out_xfer_s) begin
            main_ld_s       = 1'b1;
            main_sel_skid_s = 1'b1;
            skid_clr_s      = 1'b1;
            state_d         = FULL;
          end else begin
            state_d = SKID;
          end
        end
        default: begin
          state_d    = EMPTY;
          main_clr_s = 1'b1;
          skid_clr_s = 1'b1;
        end
      endcase
    end
  end

  // Main slot refills from the skid slot when draining, otherwise from fetch
  always_comb begin
    if (main_sel_skid_s) begin
      main_din_s = skid_data_s;
    end else begin
      main_din_s = in_data_s;
    end
  end

  pipe_slot #(.W(PW)) u_main (
    .clk     (clk),
    .rst_n   (reset),
    .ld_i    (main_ld_s),
    .clr_i   (main_clr_s),
    .data_i  (main_din_s),
    .valid_o (main_valid_s),
    .data_o  (main_data_s)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clk     (clk),
    .rst_n   (reset),
    .ld_i    (skid_ld_s),
    .clr_i   (skid_clr_s),
    .data_i  (in_data_s),
    .valid_o (skid_valid_s),
    .data_o  (skid_data_s)
  );

`ifdef IF_ID_BUBBLE_NOP_EN
  // Clean bubble towards decode while the main slot is empty
  always_comb begin
    if (main_valid_s) begin
      out_pc    = main_data_s[PW-1:INSTR_W];
      out_instr = main_data_s[INSTR_W-1:0];
    end else begin
      out_pc    = {ADDR_W{1'b0}};
      out_instr = INSTR_W'(NOP_INSTR);
    end
  end
`else
  assign out_pc    = main_data_s[PW-1:INSTR_W];
  assign out_instr = main_data_s[INSTR_W-1:0];
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Scoreboard bench for if_id_stage_reg: the driver queues accepted beats, a negedge
// monitor pops and compares every decode-side transfer.
module tb_if_id_stage_reg;

  localparam int AW = 64;
  localparam int IW = 32;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_pc;
  logic [IW-1:0] in_instr;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_instr;

  int checks = 0;
  int errors = 0;
  logic [AW+IW-1:0] sb_q[$];

  if_id_stage_reg #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] pc);
    return pc[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every decode-side transfer must match the oldest expected beat
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got pc %0h expected no beat", out_pc);
      end else begin
        logic [AW+IW-1:0] exp_beat;
        exp_beat = sb_q.pop_front();
        if ({out_pc, out_instr} !== exp_beat) begin
          errors++;
          $display("FAIL beat_order: got pc %0h instr %0h expected pc %0h instr %0h",
                   out_pc, out_instr, exp_beat[AW+IW-1:IW], exp_beat[IW-1:0]);
        end
      end
    end
  end

  // One cycle: drive at posedge+1, record acceptance at negedge, end at next posedge+1
  task automatic step(input logic iv, input logic [AW-1:0] pc, input logic ordy, input logic fl);
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    if (iv && in_ready && !fl) sb_q.push_back({pc, instr_of(pc)});
    @(posedge clk);
    #1;
    if (fl) sb_q.delete();
    flush = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", AW'(out_valid), 64'd0);
    chk("reset_in_ready", AW'(in_ready), 64'd1);
    chk("reset_out_pc", out_pc, 64'd0);
`ifdef IF_ID_BUBBLE_NOP_EN
    chk("reset_out_instr", AW'(out_instr), 64'hD503201F);
`else
    chk("reset_out_instr", AW'(out_instr), 64'd0);
`endif
    reset = 1'b1;

    // Streaming
    step(1'b1, 64'h00, 1'b1, 1'b0);
    chk("stream_v0", AW'(out_valid), 64'd1);
    chk("stream_pc0", out_pc, 64'h00);
    step(1'b1, 64'h04, 1'b1, 1'b0);
    chk("stream_v1", AW'(out_valid), 64'd1);
    chk("stream_pc1", out_pc, 64'h04);
    step(1'b1, 64'h08, 1'b1, 1'b0);
    chk("stream_v2", AW'(out_valid), 64'd1);
    chk("stream_pc2", out_pc, 64'h08);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("stream_drained", AW'(out_valid), 64'd0);

    // Stall into skid, fetch holds 0x18, then release
    step(1'b1, 64'h10, 1'b0, 1'b0);
    chk("stall_rdy_full", AW'(in_ready), 64'd1);
    step(1'b1, 64'h14, 1'b0, 1'b0);
    chk("stall_rdy_skid", AW'(in_ready), 64'd0);
    step(1'b1, 64'h18, 1'b0, 1'b0);
    chk("stall_hold_rdy", AW'(in_ready), 64'd0);
    chk("stall_hold_pc", out_pc, 64'h10);
    step(1'b1, 64'h18, 1'b1, 1'b0);
    chk("stall_drain_rdy", AW'(in_ready), 64'd1);
    chk("stall_drain_pc", out_pc, 64'h14);
    step(1'b1, 64'h18, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("stall_empty", AW'(out_valid), 64'd0);

    // Flush while in SKID with a beat offered
    step(1'b1, 64'h20, 1'b0, 1'b0);
    step(1'b1, 64'h24, 1'b0, 1'b0);
    step(1'b1, 64'h28, 1'b0, 1'b1);
    chk("flush_skid_valid", AW'(out_valid), 64'd0);
    chk("flush_skid_rdy", AW'(in_ready), 64'd1);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("flush_skid_idle", AW'(out_valid), 64'd0);

    // Flush drops a beat accepted in the same cycle
    step(1'b1, 64'h30, 1'b0, 1'b0);
    step(1'b1, 64'h34, 1'b0, 1'b1);
    chk("flush_drop_valid", AW'(out_valid), 64'd0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("flush_drop_idle", AW'(out_valid), 64'd0);

    // Out transfer coinciding with flush is still consumed
    step(1'b1, 64'h40, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b1);
    chk("flush_consume_valid", AW'(out_valid), 64'd0);

    // Simultaneous in/out for 8 cycles
    step(1'b1, 64'h50, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 64'h50 + 64'(4 * i), 1'b1, 1'b0);
      chk("simul_valid", AW'(out_valid), 64'd1);
      chk("simul_rdy", AW'(in_ready), 64'd1);
      chk("simul_pc", out_pc, 64'h50 + 64'(4 * i));
    end
    step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("idle_valid", AW'(out_valid), 64'd0);
`ifdef IF_ID_BUBBLE_NOP_EN
    chk("idle_pc", out_pc, 64'd0);
    chk("idle_instr", AW'(out_instr), 64'hD503201F);
`else
    chk("idle_pc", out_pc, 64'h70);
    chk("idle_instr", AW'(out_instr), AW'(32'h1357_9BDF ^ 32'h70));
`endif

    // Asynchronous reset in SKID
    step(1'b1, 64'h80, 1'b0, 1'b0);
    step(1'b1, 64'h84, 1'b0, 1'b0);
    chk("pre_reset_rdy", AW'(in_ready), 64'd0);
    chk("pre_reset_valid", AW'(out_valid), 64'd1);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_reset_valid", AW'(out_valid), 64'd0);
    chk("async_reset_rdy", AW'(in_ready), 64'd1);
    sb_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    step(1'b1, 64'h90, 1'b1, 1'b0);
    chk("post_reset_valid", AW'(out_valid), 64'd1);
    chk("post_reset_pc", out_pc, 64'h90);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
